power_trigger_1500: RTL

Power-threshold trigger stage directly downstream of the 1500 MSa/s matched filter. Each clock it squares the four filtered 12-bit samples and keeps a sliding sum of power over `WINDOW_CLKS` clocks. It compares that sum against a software-loaded threshold and emits a one-clock trigger pulse, followed by a holdoff interval. A saturating trigger counter is kept for rate monitoring.

---
 rtl/power_trigger_1500.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/power_trigger_1500.sv
// Power-threshold trigger: squares NSAMPS lanes, keeps a WINDOW_CLKS sliding power sum, fires a pulse then holds off.
// Optional peak tracker on output peak_o is compiled in when PWRTRIG_PEAK_EN is defined.
module power_trigger_1500 #(
    parameter  int INBITS       = 12,
    parameter  int NSAMPS       = 4,
    parameter  int WINDOW_CLKS  = 4,
    parameter  int HOLDOFF_CLKS = 32,
    localparam int PWRBITS      = 2*INBITS + 1 + $clog2(WINDOW_CLKS)
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [INBITS*NSAMPS-1:0] data_i,
    input  logic [PWRBITS-1:0]       thresh_i,
    input  logic                     thresh_valid_i,
    input  logic                     count_clr_i,
    output logic [PWRBITS-1:0]       power_o,
    output logic                     trig_o,
    output logic                     armed_o,
    output logic [15:0]              trig_count_o
`ifdef PWRTRIG_PEAK_EN
   ,output logic [PWRBITS-1:0]       peak_o
`endif
);

    localparam int SQBITS = 2*INBITS - 1;
    localparam int PSBITS = 2*INBITS + 1;

    typedef enum logic [1:0] {IDLE, ARMED, HOLDOFF} state_t;

    logic [INBITS*NSAMPS-1:0] data_q;
    logic [SQBITS-1:0]        sq_d [NSAMPS];
    logic [SQBITS-1:0]        sq_q [NSAMPS];
    logic [PSBITS-1:0]        psum_d, psum_q;
    logic [PSBITS-1:0]        hist_q [WINDOW_CLKS];
    logic [PWRBITS-1:0]       power_q;
    logic [PWRBITS-1:0]       thresh_q;
    logic                     loaded_q;
    state_t                   state_q;
    logic                     armed_q;
    logic                     trig_q;
    logic [7:0]               hold_q;
    logic [15:0]              count_d, count_q;

    // Sign-extend to full product width so the unsigned low bits equal the signed square.
    function automatic logic [SQBITS-1:0] square(input logic [INBITS-1:0] s);
        logic [2*INBITS-1:0] ext;
        ext = {{INBITS{s[INBITS-1]}}, s};
        return SQBITS'(ext * ext);
    endfunction

    // NOTE: combinational blocks use blocking '=' and assign every output first, so no latch is inferred.
    always_comb begin
        psum_d = '0;
        for (int k = 0; k < NSAMPS; k++) begin
            sq_d[k] = square(data_q[INBITS*k +: INBITS]);
            psum_d  = psum_d + PSBITS'(sq_q[k]);
        end
    end

    // NOTE: the history is a small memory that is still reset, because the subtraction relies on it starting at zero.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            data_q  <= '0;
            psum_q  <= '0;
            power_q <= '0;
            for (int k = 0; k < NSAMPS; k++) sq_q[k] <= '0;
            for (int k = 0; k < WINDOW_CLKS; k++) hist_q[k] <= '0;
        end else begin
            data_q  <= data_i;
            sq_q    <= sq_d;
            psum_q  <= psum_d;
            power_q <= power_q + PWRBITS'(psum_q) - PWRBITS'(hist_q[WINDOW_CLKS-1]);
            hist_q[0] <= psum_q;
            for (int k = 1; k < WINDOW_CLKS; k++) hist_q[k] <= hist_q[k-1];
        end
    end

    // The compare sees the registered threshold, so a same-edge load only affects later decisions.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            thresh_q <= '1;
            loaded_q <= 1'b0;
            state_q  <= IDLE;
            armed_q  <= 1'b0;
            trig_q   <= 1'b0;
            hold_q   <= '0;
        end else begin
            trig_q <= 1'b0;
            if (thresh_valid_i) begin
                thresh_q <= thresh_i;
                loaded_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (loaded_q) begin
                        state_q <= ARMED;
                        armed_q <= 1'b1;
                    end
                end
                ARMED: begin
                    if (power_q > thresh_q) begin
                        trig_q  <= 1'b1;
                        hold_q  <= 8'(HOLDOFF_CLKS - 1);
                        state_q <= HOLDOFF;
                        armed_q <= 1'b0;
                    end
                end
                HOLDOFF: begin
                    if (hold_q == 8'd0) begin
                        state_q <= ARMED;
                        armed_q <= 1'b1;
                    end else begin
                        hold_q <= hold_q - 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    armed_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        count_d = count_q;
        if (count_clr_i)
            count_d = '0;
        else if (trig_q && count_q != 16'hFFFF)
            count_d = count_q + 16'd1;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) count_q <= '0;
        else          count_q <= count_d;
    end

`ifdef PWRTRIG_PEAK_EN
    logic [PWRBITS-1:0] peak_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)              peak_q <= '0;
        else if (count_clr_i)      peak_q <= '0;
        else if (power_q > peak_q) peak_q <= power_q;
    end

    assign peak_o = peak_q;
`endif

    assign power_o      = power_q;
    assign trig_o       = trig_q;
    assign armed_o      = armed_q;
    assign trig_count_o = count_q;

endmodule
